fifo_rd_burst: RTL and testbench

Read-side master for `fifo_syn`: drains the FIFO in fixed-length bursts whenever the FIFO reports enough data (`prog_empty` low) and re-presents the words on a valid/ready stream with a last-word marker. It sits between the `fifo_syn` read port (`rden`/`dout`/`valid`/`empty`/`prog_empty`) and a downstream consumer that may stall, and provides full throughput through a 2-entry output buffer.

---
 rtl/fifo_rd_burst_pkg.sv | 43 ++++
 rtl/fifo_rd_skid.sv | 88 ++++++++
 rtl/fifo_rd_burst.sv | 170 +++++++++++++++++
 tb/tb_fifo_rd_burst.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_burst_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_burst_pkg
// Shared definitions for the fifo_syn read-side burst master:
//   - clog2           : ceiling log2 used to size counters from parameters
//   - state_e         : burst FSM state encoding (IDLE/BURST/DRAIN)
//   - prog_empty_ok   : checks that a fifo_syn programmable-empty threshold
//                       is deep enough to cover a whole burst
//   - prog_full_ok    : checks that a fifo_syn programmable-full threshold
//                       fits inside the FIFO depth
// -----------------------------------------------------------------------------
package fifo_rd_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Number of bits needed to represent values 0..value-1.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // A burst may only start once the FIFO holds at least BURST_LEN words,
    // so prog_empty must stay high until that many are present.
    function automatic bit prog_empty_ok(input int pos_value, input int burst_len);
        return (pos_value >= burst_len);
    endfunction

    // The programmable-full threshold must be reachable within the FIFO.
    function automatic bit prog_full_ok(input int pos_value, input int depth);
        return (pos_value >= 1) && (pos_value <= depth);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry in-order data+last queue sitting between the FIFO read data and
// the output stream. Entry 0 is always the head, so the output is driven
// straight from registers.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   push       in   write push_data/push_last into the queue
//   push_data  in   DWTH  word to store
//   push_last  in   last-of-burst flag stored with the word
//   pop        in   head word consumed (m_valid & m_ready)
//   occupancy  out  2    number of stored words (0..2)
//   m_valid    out  head word valid
//   m_data     out  DWTH head word
//   m_last     out  head word last flag
// -----------------------------------------------------------------------------
module fifo_rd_skid #(
    parameter int DWTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [DWTH-1:0] push_data,
    input  logic            push_last,
    input  logic            pop,
    output logic [1:0]      occupancy,
    output logic            m_valid,
    output logic [DWTH-1:0] m_data,
    output logic            m_last
);

    logic [DWTH-1:0] data_q [2];
    logic [DWTH-1:0] data_d [2];
    logic            last_q [2];
    logic            last_d [2];
    logic [1:0]      count_q;
    logic [1:0]      count_d;

    logic            pop_ok;
    logic            push_ok;
    logic [1:0]      base;

    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        pop_ok  = pop & (count_q != 2'd0);
        // Slot the new word lands in, after any same-cycle pop has shifted
        // the queue down by one.
        base    = count_q - {1'b0, pop_ok};
        // Upstream credit keeps the queue from overflowing; a push into a
        // full queue is ignored rather than corrupting the head.
        push_ok = push & (base < 2'd2);

        if (pop_ok) begin
            data_d[0] = data_q[1];
            last_d[0] = last_q[1];
        end
        if (push_ok) begin
            data_d[base[0]] = push_data;
            last_d[base[0]] = push_last;
        end
        count_d = base + {1'b0, push_ok};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= data_d[i];
                last_q[i] <= last_d[i];
            end
        end
    end

    assign occupancy = count_q;
    assign m_valid   = (count_q != 2'd0);
    assign m_data    = data_q[0];
    assign m_last    = last_q[0];

endmodule

// File: rtl/fifo_rd_burst.sv
// -----------------------------------------------------------------------------
// fifo_rd_burst
// Read-side master for fifo_syn. Waits for prog_empty to drop, reads exactly
// BURST_LEN words, and re-presents them on a valid/ready stream with m_last
// on the final word of each burst. A 2-entry output queue plus credit-based
// read issue gives one word per cycle while the consumer keeps up and never
// overflows when it stalls.
//
// Ports:
//   clk              in   clock shared with the FIFO
//   rst              in   asynchronous active-low reset
//   fifo_rden        out  read strobe to fifo_syn
//   fifo_dout        in   FIFO_DWTH  FIFO read data
//   fifo_valid       in   FIFO read data valid (1 cycle after rden)
//   fifo_empty       in   FIFO empty flag
//   fifo_prog_empty  in   FIFO programmable-empty flag
//   m_data           out  FIFO_DWTH  output word
//   m_valid          out  output word valid
//   m_ready          in   consumer ready
//   m_last           out  last word of a burst
//   busy             out  FSM not idle
//   err              out  sticky: read data arrived with no read outstanding
// -----------------------------------------------------------------------------
module fifo_rd_burst
    import fifo_rd_burst_pkg::*;
#(
    parameter int FIFO_DWTH = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 fifo_rden,
    input  logic [FIFO_DWTH-1:0] fifo_dout,
    input  logic                 fifo_valid,
    input  logic                 fifo_empty,
    input  logic                 fifo_prog_empty,
    output logic [FIFO_DWTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic                 err
);

    localparam int CNT_W = clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX_C  = CNT_W'(BURST_LEN - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] rd_cnt_q;
    logic [CNT_W-1:0] rd_cnt_d;
    logic [CNT_W-1:0] wd_cnt_q;
    logic [CNT_W-1:0] wd_cnt_d;
    logic             inflight_q;
    logic             inflight_d;
    logic             err_q;
    logic             err_d;

    logic [1:0]       occupancy;
    logic             pop;
    logic             push;
    logic             push_last;
    logic [2:0]       credit_sum;
    logic             credit;
    logic             rden;

    // ------------------------------------------------------------------
    // Read issue. Words already buffered plus the one still coming back
    // from the FIFO, minus the one leaving this cycle, must leave room for
    // another word; that bounds the queue at 2 entries.
    // ------------------------------------------------------------------
    assign pop        = m_valid & m_ready;
    assign credit_sum = {1'b0, occupancy} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit     = (credit_sum < 3'd2);
    assign rden       = (state_q == ST_BURST) & ~fifo_empty
                        & (rd_cnt_q < BURST_LEN_C) & credit;

    // Read data is only trusted when a read was issued the cycle before;
    // anything else is flagged and dropped.
    assign push       = fifo_valid & inflight_q;
    assign push_last  = (wd_cnt_q == LAST_IDX_C);

    // ------------------------------------------------------------------
    // FSM and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        wd_cnt_d = wd_cnt_q;

        if (rden) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
        if (push) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_prog_empty) begin
                    state_d  = ST_BURST;
                    rd_cnt_d = '0;
                    wd_cnt_d = '0;
                end
            end
            ST_BURST: begin
                // Empty FIFO simply pauses rden; the burst continues once
                // data returns, so there is no timeout path here.
                if (rden && (rd_cnt_q == LAST_IDX_C)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leaving only once the last word has been accepted keeps
                // m_last aligned with burst boundaries.
                if ((occupancy == 2'd0) && !inflight_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        inflight_d = rden;
        err_d      = err_q | (fifo_valid & ~inflight_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rd_cnt_q   <= '0;
            wd_cnt_q   <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Output queue
    // ------------------------------------------------------------------
    fifo_rd_skid #(
        .DWTH (FIFO_DWTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_dout),
        .push_last (push_last),
        .pop       (pop),
        .occupancy (occupancy),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    assign fifo_rden = rden;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_fifo_rd_burst.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_burst
// Bench for fifo_rd_burst with a behavioural fifo_syn model (queue) and an
// ordered scoreboard of every word written. Every accepted output word must
// be the next word written, with m_last on every 4th accepted word.
// -----------------------------------------------------------------------------
module tb_fifo_rd_burst;

    localparam int DW = 4;
    localparam int BL = 4;

    logic          clk;
    logic          rst;
    logic          fifo_rden;
    logic [DW-1:0] fifo_dout;
    logic          fifo_valid;
    logic          fifo_empty;
    logic          fifo_prog_empty;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          err;

    fifo_rd_burst #(
        .FIFO_DWTH (DW),
        .BURST_LEN (BL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_rden       (fifo_rden),
        .fifo_dout       (fifo_dout),
        .fifo_valid      (fifo_valid),
        .fifo_empty      (fifo_empty),
        .fifo_prog_empty (fifo_prog_empty),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_last          (m_last),
        .busy            (busy),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    logic [DW-1:0] fq[$];          // FIFO contents
    logic [DW-1:0] exp_q[$];       // words still owed to the consumer
    logic [DW-1:0] wr_pending[$];  // writes applied at the next edge
    int            rd_total = 0;
    int            acc_total = 0;
    int            last_fin_cyc = -1;
    bit            prev_hold = 0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    int            ready_mode = 0; // 0 low, 1 high, 2 pattern 1,0,0, 3 random
    bit            inject = 0;
    int            rden_log[$];
    int            acc_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: monitor at negedge, then model the FIFO and drive inputs
    // 1 time unit after the posedge.
    task automatic cycle();
        bit            rden_s;
        bit            pop_s;
        logic [DW-1:0] w;
        @(negedge clk);
        cyc++;
        rden_s = fifo_rden;
        pop_s  = m_valid & m_ready;
        if (rden_s) begin
            check("rden_when_empty", (fq.size() != 0), 1);
            if ((rd_total % BL) == 0 && last_fin_cyc >= 0)
                check("burst_gap", (cyc - last_fin_cyc >= 3), 1);
        end
        check("held_le2", ((rd_total - acc_total) <= 2), 1);
        if (prev_hold) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, prev_data);
            check("hold_last", m_last, prev_last);
        end
        if (pop_s) begin
            if (exp_q.size() == 0) begin
                check("extra_word", 0, 1);
            end else begin
                w = exp_q.pop_front();
                check("out_data", m_data, w);
                check("out_last", m_last, ((acc_total % BL) == BL - 1));
                if ((acc_total % BL) == BL - 1) last_fin_cyc = cyc;
            end
            acc_total++;
            acc_log.push_back(cyc);
            $display("t=%0t cyc=%0d accept data=%0h last=%0b", $time, cyc, m_data, m_last);
        end
        if (rden_s) begin
            rd_total++;
            rden_log.push_back(cyc);
        end
        prev_hold = m_valid & ~m_ready;
        prev_data = m_data;
        prev_last = m_last;

        @(posedge clk);
        #1;
        if (rden_s && fq.size() > 0) begin
            fifo_dout  = fq.pop_front();
            fifo_valid = 1'b1;
        end else begin
            fifo_valid = inject;
            fifo_dout  = inject ? 4'hA : 4'h0;
        end
        inject = 0;
        while (wr_pending.size() > 0) begin
            w = wr_pending.pop_front();
            fq.push_back(w);
            exp_q.push_back(w);
        end
        fifo_empty      = (fq.size() == 0);
        fifo_prog_empty = (fq.size() < BL);
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            2:       m_ready = ((cyc % 3) == 0);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Run until everything that can be delivered has been, within a bound.
    task automatic wait_drain(input string tag, input int bound);
        int n;
        n = 0;
        while (!(exp_q.size() == fq.size() && fq.size() < BL && !busy && !fifo_valid)
               && n < bound) begin
            cycle();
            n++;
        end
        check(tag, (n < bound), 1);
    endtask

    initial begin
        int rd0;
        int acc0;
        int cw;
        int n;

        rst = 1'b0; fifo_dout = '0; fifo_valid = 1'b0; fifo_empty = 1'b1;
        fifo_prog_empty = 1'b1; m_ready = 1'b0;
        #1;
        check("rst_rden", fifo_rden, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_mdata", m_data, 0);
        check("rst_mlast", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        repeat (3) cycle();
        rst = 1'b1;
        ready_mode = 1;
        repeat (2) cycle();

        // Single burst at full rate: 1,2,3,4
        rden_log.delete(); acc_log.delete();
        for (int i = 1; i <= 4; i++) wr_pending.push_back(4'(i));
        cycle();
        cw = cyc;
        wait_drain("t1_drain", 50);
        check("t1_nrd", rden_log.size(), 4);
        check("t1_nacc", acc_log.size(), 4);
        check("t1_first_rden", rden_log[0], cw + 2);
        check("t1_first_out", acc_log[0], cw + 4);
        for (int i = 1; i < 4; i++) begin
            check("t1_rden_seq", rden_log[i], rden_log[0] + i);
            check("t1_out_seq", acc_log[i], acc_log[0] + i);
        end
        check("t1_busy", busy, 0);

        // Three words do not start a burst; the fourth does
        rd0 = rd_total;
        for (int i = 0; i < 3; i++) wr_pending.push_back(4'(9 + i));
        repeat (8) cycle();
        check("t2_no_rden", rd_total - rd0, 0);
        check("t2_idle", busy, 0);
        wr_pending.push_back(4'hC);
        cycle();
        wait_drain("t2_drain", 50);
        check("t2_nrd", rd_total - rd0, 4);

        // Eight words, ready pattern 1,0,0: two bursts
        rd0 = rd_total; acc0 = acc_total;
        ready_mode = 2;
        for (int i = 1; i <= 8; i++) wr_pending.push_back(4'(i));
        cycle();
        wait_drain("t3_drain", 200);
        check("t3_nacc", acc_total - acc0, 8);
        check("t3_nrd", rd_total - rd0, 8);

        // Stall for 20 cycles mid-burst
        rd0 = rd_total;
        ready_mode = 0;
        for (int i = 5; i <= 8; i++) wr_pending.push_back(4'(i));
        cycle();
        repeat (20) cycle();
        check("t4_rd_stalled", rd_total - rd0, 2);
        check("t4_valid_held", m_valid, 1);
        check("t4_head", m_data, 4'h5);
        ready_mode = 1;
        wait_drain("t4_drain", 50);
        check("t4_nrd", rd_total - rd0, 4);
        check("no_err_yet", err, 0);

        // Unsolicited read data in IDLE
        acc0 = acc_total;
        inject = 1;
        cycle();
        cycle();
        check("t5_err", err, 1);
        check("t5_no_valid", m_valid, 0);
        repeat (5) cycle();
        check("t5_err_sticky", err, 1);
        check("t5_no_out", acc_total - acc0, 0);

        // Reset after 2 words of a burst
        acc0 = acc_total;
        for (int i = 1; i <= 4; i++) wr_pending.push_back(4'(i + 2));
        n = 0;
        while (acc_total - acc0 < 2 && n < 50) begin
            cycle();
            n++;
        end
        check("t6_two_words", acc_total - acc0, 2);
        #2 rst = 1'b0;
        #1;
        check("t6_rden", fifo_rden, 0);
        check("t6_mvalid", m_valid, 0);
        check("t6_mdata", m_data, 0);
        check("t6_mlast", m_last, 0);
        check("t6_busy", busy, 0);
        check("t6_err", err, 0);
        fq.delete(); exp_q.delete(); wr_pending.delete();
        fifo_valid = 1'b0; fifo_empty = 1'b1; fifo_prog_empty = 1'b1;
        rd_total = 0; acc_total = 0; prev_hold = 0; last_fin_cyc = -1;
        repeat (3) cycle();
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) wr_pending.push_back(4'(i));
        cycle();
        wait_drain("t6_drain", 50);
        check("t6_nacc", acc_total, 4);

        // Random writes and random ready
        ready_mode = 3;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) wr_pending.push_back(4'($urandom));
            cycle();
        end
        ready_mode = 1;
        wait_drain("t7_drain", 300);
        n = (BL - fq.size()) % BL;
        for (int i = 0; i < n; i++) wr_pending.push_back(4'($urandom));
        cycle();
        wait_drain("t7_final", 100);
        check("t7_all_out", exp_q.size(), 0);
        check("t7_rd_eq_acc", rd_total, acc_total);
        check("t7_no_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
